// File: rtl/perf_pkg.sv
// Shared types and constants for the branch-predictor performance-counter window controller.
package perf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        CAPTURE,
        DONE
    } perf_state_t;

    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_WINDOW     = 3'd1;
    localparam logic [2:0] REG_STATUS     = 3'd2;
    localparam logic [2:0] REG_BR_SNAP    = 3'd3;
    localparam logic [2:0] REG_HIT_SNAP   = 3'd4;
    localparam logic [2:0] REG_MISPR_SNAP = 3'd5;
    localparam logic [2:0] REG_CYC_SNAP   = 3'd6;

    localparam int CTRL_ARM    = 0;
    localparam int CTRL_STOP   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;

    localparam int WINDOW_RST = 256;

endpackage

// File: rtl/perf_cnt_ctrl.sv
// Measurement-window controller: gates pipeline event strobes into the counter bank,
// times a programmed window, snapshots the counters and raises an interrupt.
module perf_cnt_ctrl
    import perf_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_br_cnt,
    input  logic             inc_hit_cnt,
    input  logic             inc_mispr_cnt,
    input  logic [CNT_W-1:0] br_cnt,
    input  logic [CNT_W-1:0] hit_cnt,
    input  logic [CNT_W-1:0] mispr_cnt,
    output logic             br_inc_o,
    output logic             hit_inc_o,
    output logic             mispr_inc_o,
    output logic             cnt_clr,
    input  logic             mm_we,
    input  logic             mm_re,
    input  logic [2:0]       mm_addr,
    input  logic [CNT_W-1:0] mm_wdata,
    output logic [CNT_W-1:0] mm_rdata,
    output logic             mm_rvalid,
    output logic             irq
);

    perf_state_t      r_state;
    logic [CNT_W-1:0] r_window;
    logic [CNT_W-1:0] r_win_q;
    logic [CNT_W-1:0] r_cyc_q;
    logic [CNT_W-1:0] r_br_snap;
    logic [CNT_W-1:0] r_hit_snap;
    logic [CNT_W-1:0] r_mispr_snap;
    logic [CNT_W-1:0] r_cyc_snap;
    logic             r_irq_en;
    logic             r_done;
    logic [CNT_W-1:0] r_rdata;
    logic             r_rvalid;

    logic             w_run;
    logic             w_busy;
    logic             w_wr_ctrl;
    logic             w_arm;
    logic             w_stop;
    logic             w_expire;
    logic             w_w1c_done;
    logic [CNT_W-1:0] w_rdata;

    assign w_run      = (r_state == RUN);
    assign w_busy     = (r_state == CLEAR) || w_run || (r_state == CAPTURE);
    assign w_wr_ctrl  = mm_we && (mm_addr == REG_CTRL);
    // Arm is only honoured when idle or done; stop only while the window is running.
    assign w_arm      = w_wr_ctrl && mm_wdata[CTRL_ARM] && !w_busy;
    assign w_stop     = w_wr_ctrl && mm_wdata[CTRL_STOP] && w_run;
    assign w_expire   = ((r_cyc_q + CNT_W'(1)) == r_win_q);
    assign w_w1c_done = mm_we && (mm_addr == REG_STATUS) && mm_wdata[STAT_DONE];

    assign br_inc_o    = inc_br_cnt    & w_run;
    assign hit_inc_o   = inc_hit_cnt   & w_run;
    assign mispr_inc_o = inc_mispr_cnt & w_run;
    assign cnt_clr     = (r_state == CLEAR);
    assign irq         = r_done & r_irq_en;
    assign mm_rdata    = r_rdata;
    assign mm_rvalid   = r_rvalid;

    always_comb begin
        // NOTE: default first so every path assigns w_rdata and no latch is inferred.
        w_rdata = '0;
        case (mm_addr)
            REG_CTRL:       w_rdata[CTRL_IRQ_EN] = r_irq_en;
            REG_WINDOW:     w_rdata = r_window;
            REG_STATUS: begin
                w_rdata[STAT_BUSY] = w_busy;
                w_rdata[STAT_DONE] = r_done;
            end
            REG_BR_SNAP:    w_rdata = r_br_snap;
            REG_HIT_SNAP:   w_rdata = r_hit_snap;
            REG_MISPR_SNAP: w_rdata = r_mispr_snap;
            REG_CYC_SNAP:   w_rdata = r_cyc_snap;
            default:        w_rdata = '0;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_window     <= CNT_W'(WINDOW_RST);
            r_win_q      <= '0;
            r_cyc_q      <= '0;
            r_br_snap    <= '0;
            r_hit_snap   <= '0;
            r_mispr_snap <= '0;
            r_cyc_snap   <= '0;
            r_irq_en     <= 1'b0;
            r_done       <= 1'b0;
            r_rdata      <= '0;
            r_rvalid     <= 1'b0;
        end else begin
            if (mm_we && (mm_addr == REG_WINDOW))
                r_window <= mm_wdata;
            if (w_wr_ctrl)
                r_irq_en <= mm_wdata[CTRL_IRQ_EN];

            // Capture setting done wins over a same-cycle W1C.
            if (r_state == CAPTURE)
                r_done <= 1'b1;
            else if (w_arm || w_w1c_done)
                r_done <= 1'b0;

            case (r_state)
                IDLE, DONE: begin
                    if (w_arm) begin
                        r_win_q <= r_window;
                        r_state <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_cyc_q <= '0;
                    r_state <= (r_win_q == '0) ? CAPTURE : RUN;
                end
                RUN: begin
                    r_cyc_q <= r_cyc_q + CNT_W'(1);
                    if (w_expire || w_stop)
                        r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_br_snap    <= br_cnt;
                    r_hit_snap   <= hit_cnt;
                    r_mispr_snap <= mispr_cnt;
                    r_cyc_snap   <= r_cyc_q;
                    r_state      <= DONE;
                end
                default: r_state <= IDLE;
            endcase

            r_rvalid <= mm_re && !mm_we;
            if (mm_re && !mm_we)
                r_rdata <= w_rdata;
        end
    end

endmodule

// File: tb/tb_perf_cnt_ctrl.sv
// Self-checking bench for perf_cnt_ctrl: timeline-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_perf_cnt_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             inc_br_cnt, inc_hit_cnt, inc_mispr_cnt;
    logic [CNT_W-1:0] br_cnt, hit_cnt, mispr_cnt;
    logic             br_inc_o, hit_inc_o, mispr_inc_o, cnt_clr;
    logic             mm_we, mm_re;
    logic [2:0]       mm_addr;
    logic [CNT_W-1:0] mm_wdata, mm_rdata;
    logic             mm_rvalid, irq;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    perf_cnt_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .inc_br_cnt(inc_br_cnt), .inc_hit_cnt(inc_hit_cnt), .inc_mispr_cnt(inc_mispr_cnt),
        .br_cnt(br_cnt), .hit_cnt(hit_cnt), .mispr_cnt(mispr_cnt),
        .br_inc_o(br_inc_o), .hit_inc_o(hit_inc_o), .mispr_inc_o(mispr_inc_o),
        .cnt_clr(cnt_clr),
        .mm_we(mm_we), .mm_re(mm_re), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
        .mm_rdata(mm_rdata), .mm_rvalid(mm_rvalid), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Environment: counter bank driven by the DUT's gated strobes and clear pulse.
    always @(posedge clk) begin
        if (rst || cnt_clr) begin
            br_cnt <= '0; hit_cnt <= '0; mispr_cnt <= '0;
        end else begin
            if (br_inc_o)    br_cnt    <= br_cnt + 1'b1;
            if (hit_inc_o)   hit_cnt   <= hit_cnt + 1'b1;
            if (mispr_inc_o) mispr_cnt <= mispr_cnt + 1'b1;
        end
    end

    // Reference model: a run is a timeline [t_arm = clear cycle, t_cap = capture cycle].
    typedef enum int {P_IDLE, P_CLEAR, P_RUN, P_CAP} phase_t;

    int          m_cyc = 0;
    bit          m_started = 0;
    bit          m_active = 0;
    int          m_t_arm = 0;
    int          m_t_cap = 0;
    bit          m_done = 0;
    bit          m_irq_en = 0;
    int          m_window = 256;
    int          m_ev_br = 0, m_ev_hit = 0, m_ev_mispr = 0;
    int          m_snap_br = 0, m_snap_hit = 0, m_snap_mispr = 0, m_snap_cyc = 0;
    bit          m_rvalid = 0;
    int          m_rdata = 0;
    int          m_prev;
    phase_t      m_ph;
    bit          m_busy;
    int          mode = 0;

    function automatic phase_t phase(input int k);
        if (!m_active)       return P_IDLE;
        if (k == m_t_arm)    return P_CLEAR;
        if (k <  m_t_cap)    return P_RUN;
        return P_CAP;
    endfunction

    function automatic int model_reg(input int a, input bit busy);
        case (a)
            0:       return m_irq_en ? 4 : 0;
            1:       return m_window;
            2:       return (m_done ? 2 : 0) + (busy ? 1 : 0);
            3:       return m_snap_br;
            4:       return m_snap_hit;
            5:       return m_snap_mispr;
            6:       return m_snap_cyc;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        m_prev = m_cyc;
        m_ph   = phase(m_prev);
        m_busy = (m_ph != P_IDLE);
        if (rst) begin
            m_started = 1; m_active = 0; m_done = 0; m_irq_en = 0; m_window = 256;
            m_snap_br = 0; m_snap_hit = 0; m_snap_mispr = 0; m_snap_cyc = 0;
            m_rvalid = 0; m_rdata = 0;
        end else begin
            m_rvalid = mm_re && !mm_we;
            if (m_rvalid) m_rdata = model_reg(int'(mm_addr), m_busy);
            if (m_ph == P_RUN) begin
                m_ev_br    += int'(inc_br_cnt);
                m_ev_hit   += int'(inc_hit_cnt);
                m_ev_mispr += int'(inc_mispr_cnt);
            end
            if (m_ph == P_CAP) begin
                m_snap_br = m_ev_br; m_snap_hit = m_ev_hit; m_snap_mispr = m_ev_mispr;
                m_snap_cyc = m_t_cap - m_t_arm - 1;
                m_active = 0;
                m_done = 1;
            end
            if (mm_we) begin
                case (int'(mm_addr))
                    0: begin
                        m_irq_en = mm_wdata[2];
                        if (mm_wdata[0] && !m_busy) begin
                            m_active = 1; m_done = 0;
                            m_t_arm = m_prev + 1;
                            m_t_cap = m_prev + 2 + m_window;
                            m_ev_br = 0; m_ev_hit = 0; m_ev_mispr = 0;
                        end
                        if (mm_wdata[1] && m_ph == P_RUN && (m_prev + 1) < m_t_cap)
                            m_t_cap = m_prev + 1;
                    end
                    1: m_window = int'(mm_wdata);
                    2: if (mm_wdata[1] && m_ph != P_CAP) m_done = 0;
                    default: ;
                endcase
            end
        end
        m_cyc = m_prev + 1;
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (m_started) begin
            check("br_inc_o",    br_inc_o,    inc_br_cnt    && phase(m_cyc) == P_RUN);
            check("hit_inc_o",   hit_inc_o,   inc_hit_cnt   && phase(m_cyc) == P_RUN);
            check("mispr_inc_o", mispr_inc_o, inc_mispr_cnt && phase(m_cyc) == P_RUN);
            check("cnt_clr",     cnt_clr,     phase(m_cyc) == P_CLEAR);
            check("irq",         irq,         m_done && m_irq_en);
            check("mm_rvalid",   mm_rvalid,   m_rvalid);
            if (m_rvalid) check("mm_rdata", mm_rdata, m_rdata);
        end
    end

    // Raw event stimulus patterns.
    always @(posedge clk) begin
        #1;
        case (mode)
            1:       begin inc_br_cnt = 1; inc_hit_cnt = 0; inc_mispr_cnt = 0; end
            2:       begin inc_br_cnt = 1; inc_hit_cnt = (m_cyc % 2 == 0); inc_mispr_cnt = (m_cyc % 3 == 0); end
            3:       begin inc_br_cnt = 1; inc_hit_cnt = 1; inc_mispr_cnt = 1; end
            default: begin inc_br_cnt = 0; inc_hit_cnt = 0; inc_mispr_cnt = 0; end
        endcase
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [2:0] a, input logic [CNT_W-1:0] d);
        mm_addr = a; mm_wdata = d; mm_we = 1;
        tick();
        mm_we = 0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [CNT_W-1:0] d);
        mm_addr = a; mm_re = 1;
        tick();
        mm_re = 0;
        check("rvalid_after_re", mm_rvalid, 1);
        d = mm_rdata;
    endtask

    task automatic wait_irq(input int budget);
        int n = 0;
        while (!irq && n < budget) begin tick(); n++; end
        check("irq_within_budget", irq, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [CNT_W-1:0] d;

    initial begin
        rst = 1; mm_we = 0; mm_re = 0; mm_addr = '0; mm_wdata = '0;
        inc_br_cnt = 0; inc_hit_cnt = 0; inc_mispr_cnt = 0;
        tick(2);
        rst = 0;

        // Reset state of every register.
        check("irq_reset", irq, 0);
        rd(3'd0, d); check("ctrl_reset", d, 0);
        rd(3'd1, d); check("window_reset", d, 256);
        rd(3'd2, d); check("status_reset", d, 0);
        for (int a = 3; a < 8; a++) begin
            rd(3'(a), d); check("reg_reset", d, 0);
        end

        // Full window of 10 with br every cycle.
        mode = 1;
        wr(3'd1, 16'd10);
        wr(3'd0, 16'h5);
        wait_irq(40);
        rd(3'd3, d); check("br_snap_w10", d, 10);
        rd(3'd4, d); check("hit_snap_w10", d, 0);
        rd(3'd6, d); check("cyc_snap_w10", d, 10);
        rd(3'd2, d); check("status_done", d, 2);
        check("irq_set", irq, 1);
        wr(3'd2, 16'h2);
        check("irq_after_w1c", irq, 0);

        // Stop at RUN cycle 5 of a 100-cycle window.
        mode = 2;
        wr(3'd1, 16'd100);
        wr(3'd0, 16'h5);
        tick(6);
        wr(3'd0, 16'h6);
        wait_irq(10);
        rd(3'd6, d); check("cyc_snap_stop", d, 6);
        rd(3'd3, d); check("br_snap_stop", d, 6);
        rd(3'd4, d);
        rd(3'd5, d);
        wr(3'd2, 16'h2);

        // Zero window: CLEAR then straight to CAPTURE.
        mode = 3;
        wr(3'd1, 16'd0);
        wr(3'd0, 16'h5);
        wait_irq(10);
        for (int a = 3; a < 7; a++) begin
            rd(3'(a), d); check("snap_w0", d, 0);
        end
        rd(3'd2, d); check("status_w0", d, 2);
        wr(3'd2, 16'h2);

        // Re-arm and WINDOW change during RUN do not disturb the current run.
        mode = 1;
        wr(3'd1, 16'd8);
        wr(3'd0, 16'h5);
        tick(3);
        wr(3'd1, 16'd20);
        wr(3'd0, 16'h5);
        wait_irq(20);
        rd(3'd6, d); check("cyc_snap_old_window", d, 8);
        rd(3'd3, d); check("br_snap_old_window", d, 8);
        rd(3'd1, d); check("window_stored", d, 20);
        mm_addr = 3'd2; mm_wdata = 16'h2; mm_we = 1; mm_re = 1;
        tick();
        mm_we = 0; mm_re = 0;
        check("rvalid_we_re", mm_rvalid, 0);
        check("irq_w1c_we_re", irq, 0);

        // Reset in the middle of a run.
        wr(3'd1, 16'd50);
        wr(3'd0, 16'h1);
        tick(5);
        rst = 1;
        tick();
        rst = 0;
        check("br_inc_after_rst", br_inc_o, 0);
        check("irq_after_rst", irq, 0);
        rd(3'd2, d); check("status_after_rst", d, 0);
        rd(3'd1, d); check("window_after_rst", d, 256);
        rd(3'd0, d); check("ctrl_after_rst", d, 0);

        mode = 0;
        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/perf_cnt_ctrl.md
# perf_cnt_ctrl

Measurement-window controller for the branch-predictor performance counters. It gates the pipeline's branch, hit and mispredict increment strobes into the counter bank and clears that bank at the start of each run. It also times a programmed cycle window, then snapshots the counter values and raises an interrupt. The CPU configures and reads the block through a small memory-mapped register port; the block sits between the pipeline event strobes, the counter bank and the MMIO decode.

## Interface
- CNT_W, 16, width of counters, snapshots, window and data bus
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- inc_br_cnt / inc_hit_cnt / inc_mispr_cnt  in  1 each  raw event strobes from the pipeline
- br_cnt / hit_cnt / mispr_cnt  in  CNT_W each  live values from the counter bank
- br_inc_o / hit_inc_o / mispr_inc_o  out  1 each  gated strobes to the counter bank
- cnt_clr  out  1  synchronous clear pulse to the counter bank
- mm_we  in  1  register write strobe
- mm_re  in  1  register read strobe
- mm_addr  in  3  register index
- mm_wdata  in  CNT_W  write data
- mm_rdata  out  CNT_W  read data, registered
- mm_rvalid  out  1  one-cycle read-data-valid pulse
- irq  out  1  level interrupt, equal to done & irq_en

## Operation
- **Register map**
  - 0 CTRL: bit0 arm (W, self-clearing), bit1 stop (W, self-clearing), bit2 irq_en (RW).
  - 1 WINDOW: RW; reset value 256.
  - 2 STATUS: bit0 busy (RO), bit1 done (W1C).
  - 3 BR_SNAP, 4 HIT_SNAP, 5 MISPR_SNAP, 6 CYC_SNAP: RO.
  - 7: unmapped; reads 0, writes ignored.
- **FSM states:** IDLE, CLEAR, RUN, CAPTURE, DONE.
  - IDLE or DONE, on a write of arm=1 → CLEAR. Arm also clears done and latches WINDOW into win_q.
  - CLEAR: cnt_clr=1 for exactly 1 cycle; cyc_q←0. Next state is RUN, or CAPTURE if win_q==0.
  - RUN: gated strobes = raw strobes; cyc_q increments each cycle. Go to CAPTURE when cyc_q+1==win_q, or in the cycle after a stop write.
  - CAPTURE: strobes gated off. Load BR/HIT/MISPR_SNAP from the live inputs and CYC_SNAP from cyc_q. Set done. Next state is DONE.
  - DONE: hold until the next arm.
- busy = (state ∈ {CLEAR, RUN, CAPTURE}).
- Gated strobe outputs are combinational: raw & (state==RUN). In every other state they are 0.
- **Ignored writes**
  - Arm written while busy: ignored.
  - Stop written outside RUN: ignored.
  - WINDOW written while busy: stored, but affects only the next arm.
- **Simultaneous events**
  - Window expiry and stop in the same cycle: a single CAPTURE.
  - mm_we and mm_re in the same cycle: the write is performed, the read is dropped, and mm_rvalid stays 0.
  - W1C of done and entry into CAPTURE in the same cycle: done is set (the set wins).
- cyc_q is CNT_W wide. Since win_q ≤ 2^CNT_W−1, cyc_q never wraps.

## Timing
- **Reset values:** state=IDLE. All outputs are 0. WINDOW=256, irq_en=0, snapshots=0, done=0.
- Reset asserted in any state returns to IDLE on the next edge. cnt_clr is not issued by reset; the counter bank has its own reset.
- **Arm write at edge t**
  - CLEAR during cycle t+1.
  - RUN during cycles t+2 … t+1+W.
  - CAPTURE at t+2+W.
  - DONE from t+3+W. irq and snapshots are visible from t+3+W.
- Counters increment at the end of the last RUN cycle, so CAPTURE samples them after that last update.
- **Read:** mm_re at edge t → mm_rdata and mm_rvalid are valid in cycle t+1. mm_rdata holds its value until the next read.
- Writes take effect at the edge on which mm_we is sampled.

## Structure
- **Package perf_pkg:**
  - state enum perf_state_t
  - register index constants (REG_CTRL … REG_CYC_SNAP)
  - CTRL and STATUS bit positions
  - WINDOW reset constant
- **Modules:** single module; no sub-module needed. The read mux stays inline.

## Test plan
- Reset, then read all 7 registers → CTRL=0, WINDOW=256, STATUS=0, all snapshots 0; irq=0; mm_rvalid asserted one cycle after each mm_re.
- WINDOW=10, irq_en=1, arm; drive inc_br_cnt every cycle from a model counter bank → cnt_clr pulses once; after 10 RUN cycles BR_SNAP=10, CYC_SNAP=10, STATUS=0b10, irq=1; W1C done → irq=0.
- WINDOW=100, arm, stop written at RUN cycle 5 → CYC_SNAP=6; strobes gated to 0 from CAPTURE onward.
- WINDOW=0, arm → CLEAR then CAPTURE; all snapshots 0, done=1; events during CLEAR are not passed to the counter bank.
- Arm written during RUN, and WINDOW changed during RUN → current run completes with the old window; mm_we+mm_re in the same cycle → no mm_rvalid.
- Assert rst during RUN → next cycle IDLE, gated strobes 0, done=0, WINDOW=256.
